move_issuer: RTL

Move-entry front end for the 3x3 game board: turns player button presses into the one-hot square pulses that the board-occupancy accumulator adds into its position register. It keeps a cursor over the nine squares and refuses occupied squares by reading the accumulator's occupancy vector back. It also alternates the turn and stops issuing once all nine squares are taken. It sits between the debounced board buttons and the board accumulator.

---
 rtl/game_pkg.sv | 30 +++
 rtl/btn_edge_sync.sv | 31 +++
 rtl/move_issuer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the 3x3 game board: sizes, move-issue FSM states and
// the index-to-one-hot helper used by the move issuer and the display logic.
package game_pkg;

  localparam int N_SQUARES = 9;
  localparam int CURSOR_W  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    ISSUE  = 3'd2,
    SETTLE = 3'd3,
    FULL   = 3'd4
  } state_t;

  // Out-of-range indices give an all-zero vector rather than an aliased square.
  function automatic logic [N_SQUARES-1:0] onehot9(input logic [CURSOR_W-1:0] idx);
    logic [N_SQUARES-1:0] vec;
    vec = '0;
    for (int i = 0; i < N_SQUARES; i++) begin
      if (idx == CURSOR_W'(i)) begin
        vec[i] = 1'b1;
      end else begin
        vec[i] = 1'b0;
      end
    end
    return vec;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Button synchronizer (SYNC_STAGES flops, at least 2) followed by a registered
// rising-edge detector: one press gives one single-cycle pulse.
module btn_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   last_r;
  logic                   pulse_r;

  // Synchronizer chain, previous-level flop and registered edge pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r  <= '0;
      last_r  <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], btn};
      last_r  <= sync_r[SYNC_STAGES-1];
      pulse_r <= sync_r[SYNC_STAGES-1] & ~last_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/move_issuer.sv
// Move-entry front end: cursor over nine squares, occupancy check against the
// accumulator read-back, one-cycle one-hot move pulse, turn and move counting.
module move_issuer #(
  parameter int N_SQUARES   = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_next,
  input  logic                 btn_prev,
  input  logic                 btn_select,
  input  logic [N_SQUARES-1:0] posiciones,
  output logic [N_SQUARES-1:0] cuadros,
  output logic [3:0]           cursor,
  output logic [N_SQUARES-1:0] cursor_onehot,
  output logic                 turn,
  output logic [3:0]           move_count,
  output logic                 board_full,
  output logic                 reject
);

  import game_pkg::*;

  localparam logic [3:0] LAST_SQ   = 4'(N_SQUARES - 1);
  localparam logic [3:0] MAX_MOVES = 4'(N_SQUARES);

  logic next_e;
  logic prev_e;
  logic sel_e;

  state_t               state_r,   state_s;
  logic [3:0]           cursor_r,  cursor_s;
  logic [N_SQUARES-1:0] onehot_r,  onehot_s;
  logic [N_SQUARES-1:0] target_r,  target_s;
  logic [N_SQUARES-1:0] cuadros_r, cuadros_s;
  logic                 reject_r,  reject_s;
  logic                 turn_r,    turn_s;
  logic [3:0]           count_r,   count_s;
  logic                 full_r,    full_s;

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_next (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_next),
    .pulse (next_e)
  );

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_prev (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_prev),
    .pulse (prev_e)
  );

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sel (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_select),
    .pulse (sel_e)
  );

  // Next-state and next-output logic; the move pulse is loaded on CHECK->ISSUE
  // so that the registered cuadros is high exactly while the FSM sits in ISSUE.
  always_comb begin
    state_s   = state_r;
    cursor_s  = cursor_r;
    target_s  = target_r;
    cuadros_s = '0;
    reject_s  = 1'b0;
    turn_s    = turn_r;
    count_s   = count_r;
    full_s    = full_r;
    case (state_r)
      IDLE: begin
        if (sel_e) begin
          target_s = onehot9(cursor_r);
          state_s  = CHECK;
        end else if (next_e && !prev_e) begin
          cursor_s = (cursor_r == LAST_SQ) ? 4'd0 : cursor_r + 4'd1;
        end else if (prev_e && !next_e) begin
          cursor_s = (cursor_r == 4'd0) ? LAST_SQ : cursor_r - 4'd1;
        end else begin
          cursor_s = cursor_r;
        end
      end
      CHECK: begin
        if ((target_r & posiciones) != '0) begin
          reject_s = 1'b1;
          state_s  = IDLE;
        end else begin
          cuadros_s = target_r;
          state_s   = ISSUE;
        end
      end
      ISSUE: begin
        turn_s  = ~turn_r;
        count_s = count_r + 4'd1;
        state_s = SETTLE;
      end
      SETTLE: begin
        if (count_r == MAX_MOVES) begin
          full_s  = 1'b1;
          state_s = FULL;
        end else begin
          state_s = IDLE;
        end
      end
      FULL: begin
        full_s  = 1'b1;
        state_s = FULL;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    onehot_s = onehot9(cursor_s);
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cursor_r  <= 4'd0;
      onehot_r  <= {{(N_SQUARES-1){1'b0}}, 1'b1};
      target_r  <= '0;
      cuadros_r <= '0;
      reject_r  <= 1'b0;
      turn_r    <= 1'b0;
      count_r   <= 4'd0;
      full_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cursor_r  <= cursor_s;
      onehot_r  <= onehot_s;
      target_r  <= target_s;
      cuadros_r <= cuadros_s;
      reject_r  <= reject_s;
      turn_r    <= turn_s;
      count_r   <= count_s;
      full_r    <= full_s;
    end
  end

  assign cuadros       = cuadros_r;
  assign cursor        = cursor_r;
  assign cursor_onehot = onehot_r;
  assign turn          = turn_r;
  assign move_count    = count_r;
  assign board_full    = full_r;
  assign reject        = reject_r;

endmodule
